// File: rtl/tmem_array.sv
// Temporal spike memory: each channel captures its first spike per gamma cycle and
// replays it after a programmable delay as a step or pulse; owns the gamma counter.
module tmem_array #(
  parameter int N_CH              = 8,
  parameter int GAMMA_CYCLE_WIDTH = 128,
  parameter int PULSE_WIDTH       = 8,
  localparam int CW               = $clog2(GAMMA_CYCLE_WIDTH),
  localparam int CHW              = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            aclk,
  input  logic            rst,
  input  logic            grst,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] late,
  output logic [CW-1:0]   counter,
  input  logic            pulse_mode,
  input  logic            cfg_we,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [CW-1:0]   cfg_delay
);
  localparam logic [CW-1:0] LAST_SLOT = CW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [CW:0]   END_SLOT  = (CW+1)'(GAMMA_CYCLE_WIDTH - 2);
  localparam logic [CW:0]   MAX_FIRE  = (CW+1)'(GAMMA_CYCLE_WIDTH - 3);
  localparam logic [CW:0]   PW        = (CW+1)'(PULSE_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FIRING, S_DONE} ch_state_e;

  ch_state_e       state_q   [N_CH];
  ch_state_e       state_d   [N_CH];
  logic [CW:0]     fire_q    [N_CH];
  logic [CW:0]     fire_d    [N_CH];
  logic [CW-1:0]   dly_sh_q  [N_CH];
  logic [CW-1:0]   dly_sh_d  [N_CH];
  logic [CW-1:0]   dly_act_q [N_CH];
  logic [CW-1:0]   dly_act_d [N_CH];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0] out_q, out_d;
  logic [N_CH-1:0] late_q, late_d;
  logic            mode_q, mode_d;
  logic            boundary;
  logic [CW:0]     nxt_slot;

  always_comb begin
    logic [CW:0] fire_now;
    logic [CW:0] pulse_end;
    logic [CW:0] end_slot;
    fire_now  = '0;
    pulse_end = '0;
    end_slot  = '0;
    boundary  = grst || (cnt_q == LAST_SLOT);
    cnt_d     = grst ? '0 : cnt_q + CW'(1);
    nxt_slot  = {1'b0, cnt_q} + (CW+1)'(1);
    mode_d    = boundary ? pulse_mode : mode_q;
    for (int i = 0; i < N_CH; i++) begin
      // Write-through: a config write on the boundary edge is active in the new cycle.
      dly_sh_d[i]  = (cfg_we && cfg_ch == CHW'(i)) ? cfg_delay : dly_sh_q[i];
      dly_act_d[i] = boundary ? dly_sh_d[i] : dly_act_q[i];

      // An idle channel may capture this slot, so its fire time is formed on the fly.
      fire_now  = (state_q[i] == S_IDLE) ? ({1'b0, cnt_q} + {1'b0, dly_act_q[i]}) : fire_q[i];
      pulse_end = fire_now + PW;
      end_slot  = (mode_q && pulse_end < END_SLOT) ? pulse_end : END_SLOT;

      state_d[i] = state_q[i];
      fire_d[i]  = fire_q[i];
      late_d[i]  = late_q[i];
      if (boundary) begin
        state_d[i] = S_IDLE;
        late_d[i]  = 1'b0;
      end else begin
        unique case (state_q[i])
          S_IDLE: if (in[i]) begin
            fire_d[i] = fire_now;
            if (fire_now > MAX_FIRE) begin
              state_d[i] = S_DONE;
              late_d[i]  = 1'b1;
            end else if (nxt_slot > fire_now) begin
              state_d[i] = S_FIRING;
            end else begin
              state_d[i] = S_ARMED;
            end
          end
          S_ARMED:  if (nxt_slot > fire_now) state_d[i] = S_FIRING;
          S_FIRING: if (nxt_slot > end_slot) state_d[i] = S_DONE;
          S_DONE:   state_d[i] = S_DONE;
          default:  state_d[i] = S_IDLE;
        endcase
      end
      out_d[i] = (state_d[i] == S_FIRING);
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
      out_q  <= '0;
      late_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]   <= S_IDLE;
        fire_q[i]    <= '0;
        dly_sh_q[i]  <= '0;
        dly_act_q[i] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      out_q     <= out_d;
      late_q    <= late_d;
      state_q   <= state_d;
      fire_q    <= fire_d;
      dly_sh_q  <= dly_sh_d;
      dly_act_q <= dly_act_d;
    end
  end

  assign out     = out_q;
  assign late    = late_q;
  assign counter = cnt_q;
endmodule

// File: tb/tb_tmem_array.sv
// Bench for tmem_array: directed scenarios plus randomized traffic against a
// spike-time model (G=16, PW=4, 8 channels).
module tb_tmem_array;
  localparam int G   = 16;
  localparam int PW  = 4;
  localparam int NCH = 8;

  logic       aclk = 1'b0;
  logic       rst;
  logic       grst;
  logic [7:0] in_s;
  logic [7:0] out_s;
  logic [7:0] late_s;
  logic [3:0] counter_s;
  logic       pulse_mode;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [3:0] cfg_delay;

  int errors = 0;
  int checks = 0;

  // Model: current slot, capture slot per channel (-1 = none), delays, mode.
  int m_slot;
  int sp_t [NCH];
  int sh   [NCH];
  int act  [NCH];
  bit m_mode;
  bit pm;

  tmem_array #(.N_CH(NCH), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW)) dut (
    .aclk(aclk), .rst(rst), .grst(grst), .in(in_s), .out(out_s), .late(late_s),
    .counter(counter_s), .pulse_mode(pulse_mode), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_delay(cfg_delay)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      sp_t[i] = -1; sh[i] = 0; act[i] = 0;
    end
    m_slot = 0;
    m_mode = 1'b0;
  endtask

  function automatic bit m_out(input int i);
    int f, e;
    if (sp_t[i] < 0) return 1'b0;
    f = sp_t[i] + act[i];
    if (f > G - 3) return 1'b0;
    e = m_mode ? ((f + PW < G - 2) ? f + PW : G - 2) : G - 2;
    return (m_slot >= f + 1) && (m_slot <= e);
  endfunction

  function automatic bit m_late(input int i);
    return (sp_t[i] >= 0) && (sp_t[i] + act[i] > G - 3);
  endfunction

  task automatic tick(input logic [7:0] iv, input logic g, input logic we, input int ch, input int dly);
    in_s = iv; grst = g; cfg_we = we; cfg_ch = 3'(ch); cfg_delay = 4'(dly); pulse_mode = pm;
    @(posedge aclk);
    if (we) sh[ch] = dly;
    if (g || m_slot == G - 1) begin
      for (int i = 0; i < NCH; i++) begin
        act[i] = sh[i]; sp_t[i] = -1;
      end
      m_mode = pm;
      m_slot = 0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (sp_t[i] < 0 && iv[i]) sp_t[i] = m_slot;
      m_slot++;
    end
    #1;
    in_s = '0; grst = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic idle();
    tick(8'h00, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic run_to_slot(input int s);
    for (int n = 0; n < G; n++) begin
      idle();
      if (m_slot == s) break;
    end
  endtask

  task automatic test_reset();
    pm = 1'b0; in_s = '0; grst = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_delay = '0; pulse_mode = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (out_s !== 8'h00) begin errors++; $display("FAIL reset out: got %h want 00", out_s); end
    checks++; if (late_s !== 8'h00) begin errors++; $display("FAIL reset late: got %h want 00", late_s); end
    checks++; if (counter_s !== 4'd0) begin errors++; $display("FAIL reset counter: got %0d want 0", counter_s); end
    repeat (2) @(posedge aclk);
    #1;
    checks++; if (counter_s !== 4'd0) begin errors++; $display("FAIL reset hold counter: got %0d want 0", counter_s); end
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_pulse();
    logic exp;
    pm = 1'b1;
    tick(8'h00, 1'b0, 1'b1, 0, 3);
    run_to_slot(0);
    run_to_slot(2);
    tick(8'h01, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      exp = (m_slot >= 6 && m_slot <= 9);
      checks++; if (out_s[0] !== exp) begin errors++; $display("FAIL pulse out0 slot %0d: got %b want %b", m_slot, out_s[0], exp); end
      checks++; if (late_s[0] !== 1'b0) begin errors++; $display("FAIL pulse late0 slot %0d: got %b want 0", m_slot, late_s[0]); end
      idle();
    end
  endtask

  task automatic test_step();
    logic exp;
    pm = 1'b0;
    run_to_slot(0);
    run_to_slot(2);
    tick(8'h01, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      exp = (m_slot >= 6 && m_slot <= 14);
      checks++; if (out_s[0] !== exp) begin errors++; $display("FAIL step out0 slot %0d: got %b want %b", m_slot, out_s[0], exp); end
      checks++; if (counter_s !== 4'(m_slot)) begin errors++; $display("FAIL step counter: got %0d want %0d", counter_s, m_slot); end
      idle();
    end
  endtask

  task automatic test_late();
    logic exp;
    tick(8'h00, 1'b0, 1'b1, 1, 12);
    run_to_slot(0);
    run_to_slot(4);
    tick(8'h02, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      exp = (m_slot >= 5 && m_slot <= 15);
      checks++; if (out_s[1] !== 1'b0) begin errors++; $display("FAIL late out1 slot %0d: got %b want 0", m_slot, out_s[1]); end
      checks++; if (late_s[1] !== exp) begin errors++; $display("FAIL late late1 slot %0d: got %b want %b", m_slot, late_s[1], exp); end
      idle();
    end
  endtask

  task automatic test_truncate();
    logic exp;
    pm = 1'b1;
    tick(8'h00, 1'b0, 1'b1, 2, 0);
    run_to_slot(0);
    run_to_slot(10);
    tick(8'h04, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      exp = (m_slot >= 11 && m_slot <= 14);
      checks++; if (out_s[2] !== exp) begin errors++; $display("FAIL trunc out2 slot %0d: got %b want %b", m_slot, out_s[2], exp); end
      tick((k == 0) ? 8'h04 : 8'h00, 1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic test_cfg_boundary();
    logic exp;
    pm = 1'b0;
    run_to_slot(0);
    // Cycle A: old delay 0, new delay 5 written mid-cycle.
    run_to_slot(1);
    tick(8'h08, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      exp = (m_slot >= 2 && m_slot <= 14);
      checks++; if (out_s[3] !== exp) begin errors++; $display("FAIL cfgA out3 slot %0d: got %b want %b", m_slot, out_s[3], exp); end
      tick(8'h00, 1'b0, (m_slot == 7), 3, 5);
    end
    checks++; if (out_s[3] !== 1'b0) begin errors++; $display("FAIL cfgA out3 slot0: got %b want 0", out_s[3]); end
    // Cycle B: delay 5; a write landing in slot 15 takes effect in cycle C.
    run_to_slot(1);
    tick(8'h08, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      exp = (m_slot >= 7 && m_slot <= 14);
      checks++; if (out_s[3] !== exp) begin errors++; $display("FAIL cfgB out3 slot %0d: got %b want %b", m_slot, out_s[3], exp); end
      tick(8'h00, 1'b0, (m_slot == 15), 3, 2);
    end
    run_to_slot(1);
    tick(8'h08, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      exp = (m_slot >= 4 && m_slot <= 14);
      checks++; if (out_s[3] !== exp) begin errors++; $display("FAIL cfgC out3 slot %0d: got %b want %b", m_slot, out_s[3], exp); end
      idle();
    end
  endtask

  task automatic test_grst_rst();
    logic exp;
    pm = 1'b0;
    run_to_slot(2);
    tick(8'h01, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      exp = (m_slot >= 6);
      checks++; if (out_s[0] !== exp) begin errors++; $display("FAIL grst pre out0 slot %0d: got %b want %b", m_slot, out_s[0], exp); end
      idle();
    end
    checks++; if (out_s[0] !== 1'b1) begin errors++; $display("FAIL grst firing out0 slot 8: got %b want 1", out_s[0]); end
    tick(8'h00, 1'b1, 1'b0, 0, 0);
    checks++; if (counter_s !== 4'd0) begin errors++; $display("FAIL grst counter: got %0d want 0", counter_s); end
    checks++; if (out_s[0] !== 1'b0) begin errors++; $display("FAIL grst out0: got %b want 0", out_s[0]); end
    run_to_slot(15);
    tick(8'h10, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < G; k++) begin
      checks++; if (out_s !== 8'h00) begin errors++; $display("FAIL slot15 out slot %0d: got %h want 00", m_slot, out_s); end
      checks++; if (late_s !== 8'h00) begin errors++; $display("FAIL slot15 late slot %0d: got %h want 00", m_slot, late_s); end
      idle();
    end
    run_to_slot(3);
    tick(8'h20, 1'b0, 1'b0, 0, 0);
    checks++; if (out_s[5] !== 1'b1) begin errors++; $display("FAIL prerst out5: got %b want 1", out_s[5]); end
    idle(); idle();
    rst = 1'b1;
    #1;
    checks++; if (out_s !== 8'h00) begin errors++; $display("FAIL midrst out: got %h want 00", out_s); end
    checks++; if (late_s !== 8'h00) begin errors++; $display("FAIL midrst late: got %h want 00", late_s); end
    checks++; if (counter_s !== 4'd0) begin errors++; $display("FAIL midrst counter: got %0d want 0", counter_s); end
    #2;
    rst = 1'b0;
    m_reset();
    run_to_slot(1);
    tick(8'hFF, 1'b0, 1'b0, 0, 0);
    checks++; if (out_s !== 8'hFF) begin errors++; $display("FAIL postrst out slot2: got %h want ff", out_s); end
    checks++; if (late_s !== 8'h00) begin errors++; $display("FAIL postrst late slot2: got %h want 00", late_s); end
  endtask

  task automatic test_random();
    logic [7:0] iv;
    logic [7:0] exp_out;
    logic [7:0] exp_late;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) pm = ~pm;
      for (int b = 0; b < NCH; b++) iv[b] = ($urandom_range(0, 7) == 0);
      tick(iv, ($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      for (int i = 0; i < NCH; i++) begin
        exp_out[i]  = m_out(i);
        exp_late[i] = m_late(i);
      end
      checks++; if (out_s !== exp_out) begin errors++; $display("FAIL rand out slot %0d: got %h want %h", m_slot, out_s, exp_out); end
      checks++; if (late_s !== exp_late) begin errors++; $display("FAIL rand late slot %0d: got %h want %h", m_slot, late_s, exp_late); end
      checks++; if (counter_s !== 4'(m_slot)) begin errors++; $display("FAIL rand counter: got %0d want %0d", counter_s, m_slot); end
    end
  endtask

  initial begin
    test_reset();
    test_pulse();
    test_step();
    test_late();
    test_truncate();
    test_cfg_boundary();
    test_grst_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
